// File: rtl/nibble_serial_cla_adder.sv
// nibble_serial_cla_adder: WIDTH-bit adder that processes one nibble per cycle
// through a single 4-bit carry-lookahead slice, with a valid/ready handshake
// on both operand and result sides.
// Optional feature: define ADDER_SERIAL_SUBTRACT_EN to add the InputSubtract port
// (A - B computed as A + ~B + 1, captured at acceptance).
module nibble_serial_cla_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic             InputCarry,
`ifdef ADDER_SERIAL_SUBTRACT_EN
  input  logic             InputSubtract,
`endif
  input  logic             InputValid,
  output logic             InputReady,
  output logic [WIDTH-1:0] Output,
  output logic             OutputCarry,
  output logic             OutputOverflow,
  output logic             OutputValid,
  input  logic             OutputReady
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : gBadWidth
    $error("nibble_serial_cla_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             carry;

  logic [CW+1:0]    nibBase;
  logic [3:0]       nibA;
  logic [3:0]       nibB;
  logic [3:0]       g;
  logic [3:0]       p;
  logic [3:0]       c;
  logic             grpG;
  logic             grpP;
  logic [3:0]       nibSum;
  logic             nibCout;

  logic             acceptB;
  logic [WIDTH-1:0] captureB;
  logic             captureCarry;

  assign InputReady  = (state == IDLE);
  assign OutputValid = (state == DONE);

  // Operand conditioning at acceptance: subtraction folds into B inversion plus forced carry-in
  always_comb begin
    acceptB      = 1'b0;
`ifdef ADDER_SERIAL_SUBTRACT_EN
    acceptB      = InputSubtract;
`endif
    captureB     = acceptB ? ~InputB : InputB;
    captureCarry = acceptB ? 1'b1 : InputCarry;
  end

  // 4-bit carry-lookahead slice on the currently selected nibble
  always_comb begin
    nibBase = {count, 2'b00};
    nibA    = opA[nibBase +: 4];
    nibB    = opB[nibBase +: 4];
    g       = nibA & nibB;
    p       = nibA ^ nibB;
    c[0]    = carry;
    c[1]    = g[0] | (p[0] & carry);
    c[2]    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c[3]    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    grpG    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grpP    = &p;
    nibSum  = p ^ c;
    nibCout = grpG | (grpP & carry);
  end

  // Handshake FSM and nibble-serial datapath; c[3] on the last nibble is the carry into the MSB
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state          <= IDLE;
      count          <= '0;
      carry          <= 1'b0;
      opA            <= '0;
      opB            <= '0;
      Output         <= '0;
      OutputCarry    <= 1'b0;
      OutputOverflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InputValid) begin
            opA   <= InputA;
            opB   <= captureB;
            carry <= captureCarry;
            count <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          Output[nibBase +: 4] <= nibSum;
          carry                <= nibCout;
          count                <= count + 1'b1;
          if (count == LAST) begin
            OutputCarry    <= nibCout;
            OutputOverflow <= c[3] ^ nibCout;
            state          <= DONE;
          end
        end
        DONE: begin
          if (OutputReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nibble_serial_cla_adder.md
NIBBLE_SERIAL_CLA_ADDER -- requirements
Module: nibble_serial_cla_adder

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; SHALL be a multiple of 4 and at least 8; N = WIDTH/4 nibbles.
REQ-002 Clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 ResetN  input  1  asynchronous, active-low reset.
REQ-004 InputA  input  WIDTH  operand A.
REQ-005 InputB  input  WIDTH  operand B.
REQ-006 InputCarry  input  1  carry-in to bit 0.
REQ-007 InputValid  input  1  operands present.
REQ-008 InputReady  output  1  block can accept operands.
REQ-009 Output  output  WIDTH  registered sum.
REQ-010 OutputCarry  output  1  carry-out of the MSB.
REQ-011 OutputOverflow  output  1  two's-complement overflow.
REQ-012 OutputValid  output  1  result present.
REQ-013 OutputReady  input  1  downstream accepts result.

Function
REQ-014 The FSM SHALL have three states, IDLE, BUSY and DONE, with InputReady = (state==IDLE) and OutputValid = (state==DONE), both decoded from registered state.
REQ-015 IDLE: on an edge with InputValid&&InputReady, the block SHALL capture A, B and carry-in, clear the nibble counter to 0 and enter BUSY; otherwise it SHALL remain in IDLE.
REQ-016 BUSY: each cycle the block SHALL add nibble[count] of A and B with the running carry through one internal 4-bit carry-lookahead slice.
REQ-017 The slice SHALL compute per-bit g=a&b and p=a^b, group G and group P, sum bit i = p[i]^c[i], and carry-out = G | (P & cin).
REQ-018 BUSY SHALL write the slice sum into Output[4*count+3:4*count], latch the carry-out as the running carry, and increment count.
REQ-019 When count==N-1 in BUSY, the next state SHALL be DONE, and the block SHALL register the final carry as OutputCarry and carry-into-MSB XOR carry-out-of-MSB as OutputOverflow.
REQ-020 Latency: with acceptance at edge k, OutputValid SHALL rise after edge k+N (4 cycles for WIDTH=16).
REQ-021 DONE: Output, OutputCarry and OutputOverflow SHALL hold stable until an edge with OutputReady high, after which the state SHALL be IDLE.
REQ-022 Minimum initiation interval SHALL be N+2 cycles; the block SHALL NOT accept new operands in the same cycle that it hands off a result.
REQ-023 InputValid in BUSY or DONE SHALL be ignored, and no operand capture SHALL occur.
REQ-024 Output SHALL show partially written nibbles during BUSY; consumers SHALL sample only when OutputValid is high.
REQ-025 Arithmetic SHALL wrap modulo 2^WIDTH; for example, 0xFFFF+0x0001 gives 0x0000 with OutputCarry=1.

Reset
REQ-026 While ResetN is low, state SHALL be IDLE, count 0, running carry 0, and Output, OutputCarry, OutputOverflow and OutputValid all 0; InputReady SHALL be 1.
REQ-027 Reset asserted in BUSY or DONE SHALL abort the operation; no OutputValid SHALL follow for that operation.
REQ-028 Deassertion SHALL take effect at the next rising edge, with no spurious handshake.

Configuration
REQ-029 With macro ADDER_SERIAL_SUBTRACT_EN defined, the block SHALL add 1-bit input port InputSubtract, captured at acceptance.
REQ-030 When captured InputSubtract=1, B SHALL be used inverted and carry-in SHALL be forced to 1, ignoring InputCarry; in that mode OutputCarry=1 means no borrow.
REQ-031 Without the macro, the InputSubtract port and all related logic SHALL be absent, and behaviour SHALL match REQ-014..REQ-025.

Verification
REQ-032 A=0xFFFF, B=0x0001, Cin=0, OutputReady=1 -> Output=0x0000, OutputCarry=1, OutputOverflow=0; OutputValid rises exactly 4 cycles after the accept edge.
REQ-033 A=0x7FFF, B=0x0001, Cin=0 -> Output=0x8000, OutputCarry=0, OutputOverflow=1; A=0xA5A5, B=0x5A5A, Cin=1 -> Output=0x0000, OutputCarry=1, OutputOverflow=0.
REQ-034 Backpressure: OutputReady held low 3 cycles in DONE -> Output and flags stable and InputReady=0 throughout; a pulse of InputValid with new operands during DONE is not captured.
REQ-035 ResetN pulsed low during BUSY (count=2) -> outputs cleared immediately, InputReady=1 after release, no OutputValid; the next op 0x1234+0x1111 -> 0x2345.
REQ-036 Back-to-back: two ops with InputValid held high -> second accept occurs N+2 cycles after the first, and both results are correct.
REQ-037 With ADDER_SERIAL_SUBTRACT_EN: 0x0005-0x0007 -> Output=0xFFFE, OutputCarry=0; 0x8000-0x0001 -> Output=0x7FFF, OutputOverflow=1.
